// File: rtl/ula_acumulador_seq.sv
// Sequential N-bit ALU with accumulator, registered flags, start/busy/done
// handshake and a multi-cycle shift-add unsigned multiplier.
module ula_acumulador_seq #(
    parameter int NBITS    = 8,
    parameter int CNT_BITS = $clog2(NBITS) + 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             use_acc,
    input  logic [NBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    output logic [NBITS-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_neg,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                state_q, state_d;
    logic [NBITS-1:0]      result_q, result_d;
    logic                  zero_q, zero_d, carry_q, carry_d;
    logic                  ovf_q, ovf_d, neg_q, neg_d;
    logic                  done_q, done_d;
    logic [2*NBITS-1:0]    prod_q, prod_d, mcand_q, mcand_d;
    logic [NBITS-1:0]      mplier_q, mplier_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic                  accept;
    logic                  mul_last;
    logic [NBITS-1:0]      op_a;
    logic [NBITS:0]        sum, diff;
    logic [2*NBITS-1:0]    prod_next;
    logic                  wr_en, wr_carry, wr_ovf;
    logic [NBITS-1:0]      wr_res;

    assign accept    = start && (state_q == IDLE);
    assign mul_last  = (state_q == MUL) && (cnt_q == CNT_BITS'(1));
    assign op_a      = use_acc ? result_q : a_in;
    assign sum       = {1'b0, op_a} + {1'b0, b_in};
    assign diff      = {1'b0, op_a} - {1'b0, b_in};
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    // State register
    always_ff @(posedge clk_2) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && op == OP_MUL) state_d = MUL;
            MUL:     if (mul_last)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == MUL);
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        wr_res   = result_q;
        wr_carry = 1'b0;
        wr_ovf   = 1'b0;

        if (accept) begin
            case (op)
                OP_ADD: begin
                    wr_en    = 1'b1;
                    wr_res   = sum[NBITS-1:0];
                    wr_carry = sum[NBITS];
                    wr_ovf   = (op_a[NBITS-1] == b_in[NBITS-1]) &&
                               (sum[NBITS-1] != op_a[NBITS-1]);
                end
                OP_SUB: begin
                    wr_en    = 1'b1;
                    wr_res   = diff[NBITS-1:0];
                    wr_carry = diff[NBITS];
                    wr_ovf   = (op_a[NBITS-1] != b_in[NBITS-1]) &&
                               (diff[NBITS-1] != op_a[NBITS-1]);
                end
                OP_AND: begin
                    wr_en  = 1'b1;
                    wr_res = op_a & b_in;
                end
                default: begin
                    prod_d   = '0;
                    mcand_d  = {{NBITS{1'b0}}, op_a};
                    mplier_d = b_in;
                    cnt_d    = CNT_BITS'(NBITS);
                end
            endcase
        end else if (state_q == MUL) begin
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_BITS'(1);
            if (mul_last) begin
                wr_en  = 1'b1;
                wr_res = prod_next[NBITS-1:0];
                wr_ovf = |prod_next[2*NBITS-1:NBITS];
            end
        end

        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        if (wr_en) begin
            result_d = wr_res;
            zero_d   = (wr_res == '0);
            carry_d  = wr_carry;
            ovf_d    = wr_ovf;
            neg_d    = wr_res[NBITS-1];
            done_d   = 1'b1;
        end
    end

    // Datapath registers; reset overrides a running multiply without a done
    always_ff @(posedge clk_2) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result     = result_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_ovf   = ovf_q;
    assign flag_neg   = neg_q;
    assign done       = done_q;

endmodule
